// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA controller: halts CPU, copies one page into PPU OAM
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_wr_en_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_din_i,
    output logic        cpu_rdy_o,
    output logic        dma_active_o,
    output logic [15:0] dma_addr_o,
    input  logic [7:0]  dma_rdata_i,
    input  logic [7:0]  oam_base_i,
    output logic        oam_wr_en_o,
    output logic [7:0]  oam_addr_o,
    output logic [7:0]  oam_wdata_o,
    output logic        dma_done_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    // Index of the final byte; idx is 8 bits so the page byte never changes mid-transfer.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state_q;
    logic [7:0] page_q;
    logic [7:0] obase_q;
    logic [7:0] idx_q;
    logic       parity_q;
    logic       done_q;

    logic       hit;
    logic       in_read;
    logic       in_write;

    assign hit      = cpu_wr_en_i && (cpu_addr_i == DMA_REG_ADDR);
    assign in_read  = (state_q == READ);
    assign in_write = (state_q == WRITE);

    // Transfer sequencer; parity free-runs so reads can be steered onto even cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            obase_q  <= 8'h00;
            idx_q    <= 8'h00;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        page_q  <= cpu_din_i;
                        obase_q <= oam_base_i;
                        idx_q   <= 8'h00;
                        state_q <= HALT;
                    end
                end
                HALT: begin
                    // parity=1 here means the following cycle is already a read cycle
                    if (parity_q || !ALIGN_EN) begin
                        state_q <= READ;
                    end else begin
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    state_q <= READ;
                end
                READ: begin
                    state_q <= WRITE;
                end
                WRITE: begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Bus-side outputs are pure decodes of the state registers so reset takes effect at once.
    assign cpu_rdy_o    = (state_q == IDLE);
    assign dma_active_o = in_read || in_write;
    assign dma_addr_o   = (in_read || in_write) ? {page_q, idx_q} : 16'h0000;
    assign oam_wr_en_o  = in_write;
    assign oam_addr_o   = in_write ? (obase_q + idx_q) : 8'h00;
    assign oam_wdata_o  = in_write ? dma_rdata_i : 8'h00;
    assign dma_done_o   = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic        cpu_wr_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic [7:0]  oam_base;
    logic        oam_wr_en;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_done;

    int checks = 0;
    int errors = 0;
    int run    = 0;
    int ecnt   = 0;

    logic [15:0] exp_rd[$];
    logic [15:0] exp_oam[$];
    int          exp_len[$];

    oam_dma dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_wr_en_i  (cpu_wr_en),
        .cpu_addr_i   (cpu_addr),
        .cpu_din_i    (cpu_din),
        .cpu_rdy_o    (cpu_rdy),
        .dma_active_o (dma_active),
        .dma_addr_o   (dma_addr),
        .dma_rdata_i  (dma_rdata),
        .oam_base_i   (oam_base),
        .oam_wr_en_o  (oam_wr_en),
        .oam_addr_o   (oam_addr),
        .oam_wdata_o  (oam_wdata),
        .dma_done_o   (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: page 3 holds i^A5, other pages a distinct address-derived pattern.
    function automatic logic [7:0] memf(input logic [15:0] a);
        logic [7:0] v;
        if (a[15:8] == 8'h03) v = a[7:0] ^ 8'hA5;
        else v = (a[7:0] + a[7:0] + a[7:0]) ^ a[15:8] ^ 8'h5A;
        return v;
    endfunction

    // Synchronous memory: data appears one cycle after the address.
    always @(posedge clk) dma_rdata <= memf(dma_addr);

    // Edges since reset; the DUT's parity after edge n is n%2.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: pops and compares whenever the DUT shows a read, an OAM write or a halt end.
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            exp_rd.delete();
            exp_oam.delete();
            exp_len.delete();
        end else begin
            if (dma_active && !oam_wr_en) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else chk("rd_addr", 32'(dma_addr), 32'(exp_rd.pop_front()));
            end
            if (oam_wr_en) begin
                if (exp_oam.size() == 0) fail_now("oam_unexpected");
                else chk("oam_write", 32'({oam_addr, oam_wdata}), 32'(exp_oam.pop_front()));
            end
            if (!cpu_rdy) begin
                run++;
            end else if (run > 0) begin
                chk("done_pulse", 32'(dma_done), 32'd1);
                if (exp_len.size() == 0) fail_now("halt_unexpected");
                else chk("halt_len", 32'(run), 32'(exp_len.pop_front()));
                run = 0;
            end else if (dma_done) begin
                fail_now("done_spurious");
            end
        end
    end

    // Issue a DMA register write; expectations are queued before the DUT can act on it.
    task automatic trigger(input logic [7:0] pg, input logic [7:0] ob,
                           input bit want_align, input bit now);
        bit al;
        if (!now) begin
            @(negedge clk);
            if ((ecnt[0] == 1'b0) == want_align) @(negedge clk);
        end
        al = ecnt[0];
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            logic [7:0]  oa;
            a  = {pg, 8'(i)};
            oa = ob + 8'(i);
            exp_rd.push_back(a);
            exp_oam.push_back({oa, memf(a)});
        end
        exp_len.push_back(al ? 514 : 513);
        cpu_wr_en = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_din   = pg;
        oam_base  = ob;
        @(negedge clk);
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_din   = 8'h00;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 700 && !seen; i++) begin
            @(negedge clk);
            if (dma_done) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
    endtask

    initial begin
        bit hit40;
        rst       = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_din   = 8'h00;
        oam_base  = 8'h00;
        #1;
        chk("rst_cpu_rdy",   32'(cpu_rdy),    32'd1);
        chk("rst_dma_active",32'(dma_active), 32'd0);
        chk("rst_dma_addr",  32'(dma_addr),   32'd0);
        chk("rst_oam_wr_en", 32'(oam_wr_en),  32'd0);
        chk("rst_oam_addr",  32'(oam_addr),   32'd0);
        chk("rst_oam_wdata", 32'(oam_wdata),  32'd0);
        chk("rst_dma_done",  32'(dma_done),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // page 2, no alignment cycle, then page 2 with alignment
        trigger(8'h02, 8'h00, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        trigger(8'h02, 8'h00, 1'b1, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);

        // wrapped OAM base over the i^A5 page
        trigger(8'h03, 8'hF0, 1'b0, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);

        // re-trigger and oam_base change mid-transfer must be ignored
        trigger(8'h05, 8'h10, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        cpu_wr_en = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_din   = 8'h07;
        oam_base  = 8'h99;
        @(negedge clk);
        cpu_wr_en = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        cpu_wr_en = 1'b1;
        cpu_addr  = 16'h4013;
        cpu_din   = 8'h09;
        @(negedge clk);
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        repeat (20) @(negedge clk);
        chk("no_trigger_4013", 32'(cpu_rdy), 32'd1);

        // reset while writing idx 0x40
        trigger(8'h04, 8'h00, 1'b0, 1'b0);
        hit40 = 1'b0;
        for (int i = 0; i < 300 && !hit40; i++) begin
            @(negedge clk);
            if (oam_wr_en && oam_addr == 8'h40) hit40 = 1'b1;
        end
        if (!hit40) fail_now("idx40_timeout");
        #1;
        rst = 1'b1;
        #1;
        chk("abort_cpu_rdy",    32'(cpu_rdy),    32'd1);
        chk("abort_dma_active", 32'(dma_active), 32'd0);
        chk("abort_oam_wr_en",  32'(oam_wr_en),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        trigger(8'h06, 8'h20, 1'b1, 1'b0);
        wait_done();

        // back-to-back: second write on the cycle right after the done pulse
        @(negedge clk);
        trigger(8'h0A, 8'h08, 1'b0, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        chk("rd_queue_empty",  32'(exp_rd.size()),  32'd0);
        chk("oam_queue_empty", 32'(exp_oam.size()), 32'd0);
        chk("len_queue_empty", 32'(exp_len.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
